// File: rtl/ccg_pkg.sv
// Shared types for the programmable two-input gate network.
// Opcodes, per-output config entry and its reset value.
package ccg_pkg;

   localparam int SEL_MAX = 16;

   typedef enum logic [2:0] {
      OP_BUF  = 3'd0,
      OP_NOT  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XOR  = 3'd6,
      OP_XNOR = 3'd7
   } gate_op_e;

   typedef struct packed {
      gate_op_e             op;
      logic [SEL_MAX-1:0]   sel_a;
      logic [SEL_MAX-1:0]   sel_b;
   } cfg_entry_t;

   localparam cfg_entry_t RESET_ENTRY = '{
      op:    OP_BUF,
      sel_a: '0,
      sel_b: '0
   };

endpackage

// File: rtl/ccg_gate_net_pipe_cell.sv
// Single two-input Boolean gate, selected by opcode.
// Purely combinational.
module ccg_gate_cell
   import ccg_pkg::*;
(
   input  gate_op_e i_op,
   input  logic     i_a,
   input  logic     i_b,
   output logic     o_y
);

   always_comb begin
      o_y = 1'b0;
      unique case (i_op)
         OP_BUF:  o_y = i_a;
         OP_NOT:  o_y = ~i_a;
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_NAND: o_y = ~(i_a & i_b);
         OP_NOR:  o_y = ~(i_a | i_b);
         OP_XOR:  o_y = i_a ^ i_b;
         OP_XNOR: o_y = ~(i_a ^ i_b);
         default: o_y = 1'b0;
      endcase
   end

endmodule

// File: rtl/ccg_gate_net_pipe.sv
// Programmable gate network: runtime config table, one gate per output,
// 2-stage valid/ready pipeline with backpressure and a delivery counter.
module ccg_gate_net_pipe
   import ccg_pkg::*;
#(
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 5,
   parameter int SEL_W   = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1,
   parameter int ADDR_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [2:0]         cfg_op,
   input  logic [SEL_W-1:0]   cfg_sel_a,
   input  logic [SEL_W-1:0]   cfg_sel_b,
   output logic               cfg_err,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUM_IN-1:0]  x,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] f,
   output logic [CNT_W-1:0]   out_count
);

   cfg_entry_t          r_tbl [NUM_OUT];
   logic                r_cfg_err;
   logic                r_s1_v;
   logic                r_s2_v;
   logic [NUM_OUT-1:0]  r_s1_f;
   logic [NUM_OUT-1:0]  r_s2_f;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_wr_ok;
   logic                w_s2_load;
   logic                w_accept;
   logic                w_deliver;
   logic [NUM_OUT-1:0]  w_f_next;

   assign w_wr_ok   = (32'(cfg_addr)  < NUM_OUT)
                   && (32'(cfg_sel_a) < NUM_IN)
                   && (32'(cfg_sel_b) < NUM_IN);
   assign w_s2_load = !r_s2_v || out_ready;
   assign in_ready  = !r_s1_v || w_s2_load;
   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_s2_v && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            r_tbl[i] <= RESET_ENTRY;
         end
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_we && !w_wr_ok;
         if (cfg_we && w_wr_ok) begin
            for (int i = 0; i < NUM_OUT; i++) begin
               if (cfg_addr == ADDR_W'(i)) begin
                  r_tbl[i] <= '{
                     op:    gate_op_e'(cfg_op),
                     sel_a: SEL_MAX'(cfg_sel_a),
                     sel_b: SEL_MAX'(cfg_sel_b)
                  };
               end
            end
         end
      end
   end

   // Operand pick by one-hot mask so any select width maps cleanly onto x
   for (genvar g = 0; g < NUM_OUT; g++) begin : g_cell
      logic w_a;
      logic w_b;
      assign w_a = |(x & (NUM_IN'(1) << r_tbl[g].sel_a));
      assign w_b = |(x & (NUM_IN'(1) << r_tbl[g].sel_b));
      ccg_gate_cell u_cell (
         .i_op (r_tbl[g].op),
         .i_a  (w_a),
         .i_b  (w_b),
         .o_y  (w_f_next[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v <= 1'b0;
         r_s1_f <= '0;
         r_s2_v <= 1'b0;
         r_s2_f <= '0;
      end else begin
         if (w_accept) begin
            r_s1_v <= 1'b1;
            r_s1_f <= w_f_next;
         end else if (r_s1_v && w_s2_load) begin
            r_s1_v <= 1'b0;
         end
         if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
               r_s2_f <= r_s1_f;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_deliver && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cfg_err   = r_cfg_err;
   assign out_valid = r_s2_v;
   assign f         = r_s2_f;
   assign out_count = r_cnt;

endmodule

// File: tb/tb_ccg_gate_net_pipe.sv
// Scoreboard bench: small 2x5 instance with directed vectors,
// plus an 8x16 instance driven by random configs and a reference model.
module tb_ccg_gate_net_pipe;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   logic        a_cfg_we, a_cfg_err, a_in_valid, a_in_ready;
   logic        a_out_valid, a_out_ready;
   logic [2:0]  a_cfg_addr, a_cfg_op;
   logic [1:0]  a_sel_a, a_sel_b, a_x;
   logic [4:0]  a_f;
   logic [15:0] a_cnt;

   logic        b_cfg_we, b_cfg_err, b_in_valid, b_in_ready;
   logic        b_out_valid, b_out_ready;
   logic [3:0]  b_cfg_addr, b_sel_a, b_sel_b;
   logic [2:0]  b_cfg_op;
   logic [7:0]  b_x;
   logic [15:0] b_f, b_cnt;

   logic [4:0]  qa[$];
   logic [15:0] qb[$];

   int op_m [16];
   int sa_m [16];
   int sb_m [16];

   ccg_gate_net_pipe #(
      .NUM_IN(2), .NUM_OUT(5), .SEL_W(2), .ADDR_W(3), .CNT_W(16)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_op(a_cfg_op),
      .cfg_sel_a(a_sel_a), .cfg_sel_b(a_sel_b), .cfg_err(a_cfg_err),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .x(a_x),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .f(a_f),
      .out_count(a_cnt)
   );

   ccg_gate_net_pipe #(
      .NUM_IN(8), .NUM_OUT(16), .SEL_W(4), .ADDR_W(4), .CNT_W(16)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_op(b_cfg_op),
      .cfg_sel_a(b_sel_a), .cfg_sel_b(b_sel_b), .cfg_err(b_cfg_err),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .f(b_f),
      .out_count(b_cnt)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic ref_gate(int op, logic a, logic b);
      case (op)
         0:       return a;
         1:       return ~a;
         2:       return a & b;
         3:       return a | b;
         4:       return ~(a & b);
         5:       return ~(a | b);
         6:       return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // Monitors: pop on each delivery; A also checks output hold under stall
   logic       a_hold = 1'b0;
   logic [4:0] a_prev;
   always @(negedge clk) begin
      if (!rst_n) begin
         a_hold = 1'b0;
      end else begin
         if (a_hold) begin
            chk("a_hold_valid", 32'(a_out_valid), 32'd1);
            chk("a_hold_f", 32'(a_f), 32'(a_prev));
         end
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected f=%h", a_f);
            end else begin
               chk("a_f", 32'(a_f), 32'(qa.pop_front()));
            end
         end
         a_hold = a_out_valid && !a_out_ready;
         a_prev = a_f;
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected f=%h", b_f);
         end else begin
            chk("b_f", 32'(b_f), 32'(qb.pop_front()));
         end
      end
   end

   task automatic send_a(logic [1:0] xv, logic [4:0] ef);
      int n = 0;
      a_x = xv;
      a_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (a_in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout x=%b", xv);
            a_in_valid = 1'b0;
            return;
         end
      end
      qa.push_back(ef);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic send_b(logic [7:0] xv, logic [15:0] ef);
      int n = 0;
      b_x = xv;
      b_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (b_in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL b_accept_timeout x=%h", xv);
            b_in_valid = 1'b0;
            return;
         end
      end
      qb.push_back(ef);
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
   endtask

   task automatic drain_a();
      int n = 0;
      while (qa.size() > 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("a_drain_left", 32'(qa.size()), 32'd0);
   endtask

   task automatic drain_b();
      int n = 0;
      while (qb.size() > 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("b_drain_left", 32'(qb.size()), 32'd0);
   endtask

   task automatic cfg_a(int ad, int op, int sa, int sb, logic ee);
      @(negedge clk);
      a_cfg_we   = 1'b1;
      a_cfg_addr = 3'(ad);
      a_cfg_op   = 3'(op);
      a_sel_a    = 2'(sa);
      a_sel_b    = 2'(sb);
      @(posedge clk);
      #1;
      a_cfg_we = 1'b0;
      chk("a_cfg_err", 32'(a_cfg_err), 32'(ee));
      if (ee) begin
         @(posedge clk);
         #1;
         chk("a_cfg_err_pulse", 32'(a_cfg_err), 32'd0);
      end
   endtask

   task automatic cfg_b(int ad, int op, int sa, int sb, logic ee);
      @(negedge clk);
      b_cfg_we   = 1'b1;
      b_cfg_addr = 4'(ad);
      b_cfg_op   = 3'(op);
      b_sel_a    = 4'(sa);
      b_sel_b    = 4'(sb);
      @(posedge clk);
      #1;
      b_cfg_we = 1'b0;
      chk("b_cfg_err", 32'(b_cfg_err), 32'(ee));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      qa.delete();
      qb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      logic [7:0]  bx;
      logic [15:0] be;
      a_cfg_we = 0; a_cfg_addr = 0; a_cfg_op = 0; a_sel_a = 0; a_sel_b = 0;
      a_in_valid = 0; a_x = 0; a_out_ready = 1;
      b_cfg_we = 0; b_cfg_addr = 0; b_cfg_op = 0; b_sel_a = 0; b_sel_b = 0;
      b_in_valid = 0; b_x = 0; b_out_ready = 1;

      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_f", 32'(a_f), 32'd0);
      chk("rst_count", 32'(a_cnt), 32'd0);
      chk("rst_cfg_err", 32'(a_cfg_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);

      send_a(2'b10, 5'b00000);
      send_a(2'b01, 5'b11111);
      drain_a();

      do_reset();
      cfg_a(0, 5, 0, 1, 1'b0);
      cfg_a(1, 6, 0, 1, 1'b0);
      cfg_a(2, 0, 1, 1, 1'b0);
      cfg_a(3, 0, 0, 0, 1'b0);
      cfg_a(4, 0, 1, 1, 1'b0);
      send_a(2'b00, 5'b00001);
      first = acc_cyc;
      send_a(2'b01, 5'b01010);
      send_a(2'b10, 5'b10110);
      send_a(2'b11, 5'b11100);
      chk("throughput", 32'(acc_cyc - first), 32'd3);
      drain_a();
      chk("count_4", 32'(a_cnt), 32'd4);

      a_out_ready = 1'b0;
      fork
         begin
            send_a(2'b00, 5'b00001);
            send_a(2'b01, 5'b01010);
            send_a(2'b10, 5'b10110);
            send_a(2'b11, 5'b11100);
         end
         begin
            repeat (5) @(negedge clk);
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_out_valid", 32'(a_out_valid), 32'd1);
            @(posedge clk);
            #1;
            a_out_ready = 1'b1;
         end
      join
      drain_a();
      chk("count_8", 32'(a_cnt), 32'd8);

      a_cfg_we   = 1'b1;
      a_cfg_addr = 3'd0;
      a_cfg_op   = 3'd2;
      a_sel_a    = 2'd0;
      a_sel_b    = 2'd1;
      send_a(2'b11, 5'b11100);
      a_cfg_we = 1'b0;
      chk("same_cycle_err", 32'(a_cfg_err), 32'd0);
      send_a(2'b11, 5'b11101);
      drain_a();

      cfg_a(7, 2, 0, 0, 1'b1);
      cfg_a(1, 3, 2, 0, 1'b1);
      cfg_a(3, 1, 0, 3, 1'b1);
      send_a(2'b11, 5'b11101);
      drain_a();

      send_a(2'b00, 5'b00000);
      send_a(2'b01, 5'b01010);
      chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_count", 32'(a_cnt), 32'd0);
      qa.delete();
      qb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_valid", 32'(a_out_valid), 32'd0);
      chk("post_rst_count", 32'(a_cnt), 32'd0);
      @(posedge clk);
      #1;
      send_a(2'b01, 5'b11111);
      drain_a();

      for (int i = 0; i < 16; i++) begin
         op_m[i] = int'($urandom_range(0, 7));
         sa_m[i] = int'($urandom_range(0, 7));
         sb_m[i] = int'($urandom_range(0, 7));
         cfg_b(i, op_m[i], sa_m[i], sb_m[i], 1'b0);
      end
      cfg_b(3, 1, 9, 0, 1'b1);
      cfg_b(5, 2, 0, 8, 1'b1);
      for (int k = 0; k < 24; k++) begin
         bx = 8'($urandom);
         for (int j = 0; j < 16; j++) begin
            be[j] = ref_gate(op_m[j], bx[sa_m[j]], bx[sb_m[j]]);
         end
         send_b(bx, be);
      end
      drain_b();
      chk("b_count", 32'(b_cnt), 32'd24);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
